nxn_matrix_multiplier: RTL and testbench
========================================

# nxn_matrix_multiplier

Parametrised square matrix multiplier computing C = A·B on IEEE-754 single-precision operands for any dimension N. It replaces the fixed 2x2 fully-parallel multiplier with one shared `single_multiplier` and one shared `adder`, sequenced by an FSM. Operands are captured on acceptance, so the producer may change its inputs after the acknowledge. It uses the same Stable/Ack/Free handshake toward producer and consumer as the 2x2 block.

## Interface
- N, default 2, matrix dimension; legal range 1..4.
- input_Clk  in  1  clock; all logic on the rising edge.
- input_Reset  in  1  reset, asynchronous, active-low; also drives the rst/reset ports of both submodules.
- input_Stable  in  1  producer asserts when input_A and input_B are valid.
- input_A  in  N*N*32  matrix A, row-major; element (r,c) is at bits [(r*N+c)*32 +: 32].
- input_B  in  N*N*32  matrix B, same packing as input_A.
- output_AB_Ack  out  1  one-cycle pulse: operands captured.
- output_C  out  N*N*32  result matrix, same packing.
- output_Stable  out  1  output_C valid; held until the consumer acknowledges.
- input_C_Ack  in  1  consumer accepts output_C.
- output_Free  out  1  block idle and ready to accept new operands.

## Operation
- States: IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE.
- IDLE: output_Free=1. When input_Stable=1, capture input_A and input_B into internal registers, set i=j=k=0, then go to MUL_REQ.
- Capture also drives output_AB_Ack=1 for the next cycle only and sets output_Free=0.
- MUL_REQ: drive A[i][k] to input_a and B[k][j] to input_b. Hold input_a_stb and input_b_stb high.
  - Drop each strobe individually once its input_x_ack is seen.
  - When both acks have been seen, go to MUL_WAIT.
- MUL_WAIT: on output_z_stb, latch output_z into the product register and pulse output_z_ack for 1 cycle.
  - If k==0: acc=product and go to NEXT (no add).
  - Otherwise go to ADD_REQ.
- ADD_REQ: drive Number1=acc, Number2=product, load=1 for exactly one cycle, then go to ADD_WAIT.
- ADD_WAIT: on result_ready, acc=Result, pulse result_ack for 1 cycle, then go to NEXT.
- NEXT: if k<N-1, increment k and go to MUL_REQ.
  - Otherwise write acc to internal C buffer element (i,j) and set k=0.
  - Advance j, then i, row-major.
  - After element (N-1,N-1), copy the whole C buffer to output_C and go to DONE.
- DONE: output_Stable=1. When input_C_Ack=1, output_Stable=0 and output_Free=1 next cycle, and the state returns to IDLE.
- output_C changes only on the NEXT→DONE transition. It holds its value through IDLE until the next completion.
- input_Stable is ignored in every state except IDLE. Changes on input_A/input_B after capture have no effect.
- N=1: a single multiply, no add; C = A·B.
- Arithmetic is whatever the submodules produce: no rounding, NaN or denormal handling in this block. Accumulation order for each element is k=0..N-1, left-fold.

## Timing
- Reset values: output_C=0, output_AB_Ack=0, output_Stable=0, output_Free=1, state=IDLE, all submodule strobes/acks/load=0.
- Reset asserted mid-operation aborts immediately. Outputs and state take their reset values, and no partial result is ever presented.
- Latency depends on the submodules. Per element: N multiply handshakes plus N-1 add handshakes.
- FSM overhead per element:
  - MUL_REQ→MUL_WAIT: 1 cycle minimum.
  - k==0 path (MUL_WAIT→NEXT): 1 cycle.
  - Add path (ADD_REQ, ADD_WAIT, NEXT): 2 cycles plus the adder latency.
- Output_AB_Ack and output_Free:
  - Capture edge T: output_AB_Ack=1 in cycle T+1 only; output_Free falls at T+1.
  - output_Free stays 0 until the cycle after input_C_Ack is sampled in DONE.
- input_C_Ack sampled high in DONE: output_Stable falls at the next edge. A new input_Stable is accepted no earlier than one cycle after IDLE is re-entered.
- input_C_Ack high outside DONE is ignored.

## Test plan
- N=2, A=[1,2;3,4] (3F800000,40000000,40400000,40800000), B=[5,6;7,8] (40A00000,40C00000,40E00000,41000000) -> C=[41980000,41B00000;422C0000,42480000]. Exactly one AB_Ack pulse; Free low from capture to C_Ack.
- N=3, A=identity (3F800000 diagonal, 0 elsewhere), B=1.0..9.0 row-major -> C==B bitwise. N=1, A=40000000, B=40400000 -> C=40C00000.
- Backpressure: hold input_C_Ack=0 for 20 cycles after output_Stable rises, pulsing input_Stable meanwhile. Required: output_Stable stays 1, output_C unchanged, no second AB_Ack. Then C_Ack=1 -> Stable=0 and Free=1 one cycle later.
- Operand isolation: immediately after AB_Ack, overwrite input_A/input_B with FFFFFFFF. Required: result equals that of the originally captured operands.
- Reset mid-operation: assert input_Reset low while in ADD_WAIT. Required: all outputs go to reset values asynchronously. After release, a fresh 2x2 job completes with the correct C.
- Back-to-back: two jobs with input_Stable high continuously. Required: the second job is captured only after DONE→IDLE and produces its own correct C.

Source files
------------

// File: rtl/nxn_matrix_multiplier.sv
// nxn_matrix_multiplier: C = A*B on single-precision operands using one shared
// multiplier and one shared adder, sequenced element by element.
//
// Handshakes: a strobe/load is held (or pulsed) by the sender with its data
// stable; the receiver's ack/ready is the only thing that retires it. The
// receiver of a result (z_stb / result_ready) answers with a one-cycle ack
// pulse, after which the sender drops its valid. Producer side:
// input_Stable is honoured only in IDLE; output_AB_Ack pulses once on capture.
// Consumer side: output_Stable holds with output_C until input_C_Ack.

// Truncating float multiplier: zero-exponent operands give +0.
module single_multiplier (
  input  logic        clk,
  input  logic        rst,            // active-low, asynchronous
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [1:0]  output_State
);
  typedef enum logic [1:0] {M_GET, M_PUT} mstate_t;
  mstate_t     r_state, w_state_next;
  logic [31:0] r_a, r_b;
  logic        r_have_a, r_have_b;
  logic [24:0] w_ph;
  logic [7:0]  w_e;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= M_GET;
    else      r_state <= w_state_next;
  end

  // Next state: collect both operands, then offer the product until acked
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      M_GET:   if (r_have_a && r_have_b) w_state_next = M_PUT;
      M_PUT:   if (output_z_ack)         w_state_next = M_GET;
      default: w_state_next = M_GET;
    endcase
  end

  // Operand capture with one-cycle ack pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= '0; r_b <= '0; r_have_a <= 1'b0; r_have_b <= 1'b0;
      input_a_ack <= 1'b0; input_b_ack <= 1'b0;
    end else begin
      input_a_ack <= 1'b0;
      input_b_ack <= 1'b0;
      if (r_state == M_GET) begin
        if (input_a_stb && !r_have_a) begin
          r_a <= input_a; r_have_a <= 1'b1; input_a_ack <= 1'b1;
        end
        if (input_b_stb && !r_have_b) begin
          r_b <= input_b; r_have_b <= 1'b1; input_b_ack <= 1'b1;
        end
        if (r_have_a && r_have_b) begin
          r_have_a <= 1'b0; r_have_b <= 1'b0;
        end
      end
    end
  end

  // Product of the latched operands; top 25 bits of the 48-bit mantissa product
  always_comb begin
    w_ph = 25'((48'({1'b1, r_a[22:0]}) * 48'({1'b1, r_b[22:0]})) >> 23);
    w_e  = r_a[30:23] + r_b[30:23] + 8'(w_ph[24]) - 8'd127;
    if (r_a[30:23] == 8'd0 || r_b[30:23] == 8'd0) output_z = 32'd0;
    else output_z = {r_a[31] ^ r_b[31], w_e, w_ph[24] ? w_ph[23:1] : w_ph[22:0]};
  end

  assign output_z_stb = (r_state == M_PUT);
  assign output_State = r_state;
endmodule

// Truncating float adder: a zero-exponent operand returns the other one.
module adder (
  input  logic        clk,
  input  logic        reset,          // active-low, asynchronous
  input  logic        load,
  input  logic [31:0] Number1,
  input  logic [31:0] Number2,
  output logic [31:0] Result,
  output logic        result_ready,
  input  logic        result_ack,
  output logic [1:0]  output_State
);
  typedef enum logic [1:0] {A_IDLE, A_CALC, A_READY} astate_t;
  astate_t     r_state, w_state_next;
  logic [31:0] r_n1, r_n2, w_big, w_small, w_result;
  logic [7:0]  w_eb, w_es, w_sh;
  logic [23:0] w_mb, w_ms, w_diff;
  logic [22:0] w_norm;
  logic [24:0] w_sum25;
  logic [4:0]  w_lz;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= A_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: load -> one compute cycle -> hold result until acked
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      A_IDLE:  if (load)       w_state_next = A_CALC;
      A_CALC:                  w_state_next = A_READY;
      A_READY: if (result_ack) w_state_next = A_IDLE;
      default: w_state_next = A_IDLE;
    endcase
  end

  // Operand latch on load, result register in the compute cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n1 <= '0; r_n2 <= '0; Result <= '0;
    end else begin
      if (r_state == A_IDLE && load) begin
        r_n1 <= Number1; r_n2 <= Number2;
      end
      if (r_state == A_CALC) Result <= w_result;
    end
  end

  // Align the smaller magnitude to the larger, add or subtract, renormalise
  always_comb begin
    if (r_n2[30:0] > r_n1[30:0]) begin w_big = r_n2; w_small = r_n1; end
    else                         begin w_big = r_n1; w_small = r_n2; end
    w_eb    = w_big[30:23];
    w_es    = w_small[30:23];
    w_sh    = w_eb - w_es;
    w_mb    = {1'b1, w_big[22:0]};
    w_ms    = {1'b1, w_small[22:0]} >> w_sh;
    w_sum25 = {1'b0, w_mb} + {1'b0, w_ms};
    w_diff  = w_mb - w_ms;
    w_lz    = 5'd0;
    for (int b = 0; b < 24; b++) if (w_diff[b]) w_lz = 5'(23 - b);
    w_norm  = 23'(w_diff << w_lz);
    if (w_es == 8'd0) w_result = w_big;
    else if (w_big[31] == w_small[31]) begin
      if (w_sum25[24]) w_result = {w_big[31], w_eb + 8'd1, w_sum25[23:1]};
      else             w_result = {w_big[31], w_eb, w_sum25[22:0]};
    end else if (w_diff == 24'd0) w_result = 32'd0;
    else w_result = {w_big[31], w_eb - 8'(w_lz), w_norm};
  end

  assign result_ready = (r_state == A_READY);
  assign output_State = r_state;
endmodule

module nxn_matrix_multiplier #(
  parameter int N = 2
) (
  input  logic              input_Clk,
  input  logic              input_Reset,
  input  logic              input_Stable,
  input  logic [N*N*32-1:0] input_A,
  input  logic [N*N*32-1:0] input_B,
  output logic              output_AB_Ack,
  output logic [N*N*32-1:0] output_C,
  output logic              output_Stable,
  input  logic              input_C_Ack,
  output logic              output_Free,
  output logic [6:0]        output_Dbg_State  // {adder, multiplier, sequencer}
);
  localparam int W  = N * N * 32;
  localparam int OW = $clog2(W);
  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic [2:0] {IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE} state_t;
  state_t          r_state, w_state_next;
  logic [W-1:0]    r_a, r_b, r_cbuf, w_cbuf_upd;
  logic [2:0]      r_i, r_j, r_k;
  logic [31:0]     r_prod, r_acc, w_z, w_sum, w_mul_a, w_mul_b;
  logic            r_a_stb, r_b_stb, r_z_ack, r_load, r_res_ack;
  logic            w_a_ack, w_b_ack, w_z_stb, w_res_ready;
  logic            w_k_last, w_j_last, w_i_last;
  logic [1:0]      w_mul_state, w_add_state;
  logic [OW-1:0]   w_off_a, w_off_b, w_off_c;

  assign w_k_last = (r_k == LAST);
  assign w_j_last = (r_j == LAST);
  assign w_i_last = (r_i == LAST);

  // Element offsets for A[i][k], B[k][j] and C[i][j], plus the buffer with C[i][j] merged
  always_comb begin
    w_off_a    = OW'((int'(r_i) * N + int'(r_k)) * 32);
    w_off_b    = OW'((int'(r_k) * N + int'(r_j)) * 32);
    w_off_c    = OW'((int'(r_i) * N + int'(r_j)) * 32);
    w_mul_a    = r_a[w_off_a +: 32];
    w_mul_b    = r_b[w_off_b +: 32];
    w_cbuf_upd = r_cbuf;
    w_cbuf_upd[w_off_c +: 32] = r_acc;
  end

  // State register
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) r_state <= IDLE;
    else              r_state <= w_state_next;
  end

  // Next-state sequencing over k, then j, then i
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (input_Stable) w_state_next = MUL_REQ;
      MUL_REQ:  if ((!r_a_stb || w_a_ack) && (!r_b_stb || w_b_ack)) w_state_next = MUL_WAIT;
      MUL_WAIT: if (w_z_stb) w_state_next = (r_k == 3'd0) ? NEXT : ADD_REQ;
      ADD_REQ:  w_state_next = ADD_WAIT;
      ADD_WAIT: if (w_res_ready) w_state_next = NEXT;
      NEXT:     w_state_next = (w_k_last && w_i_last && w_j_last) ? DONE : MUL_REQ;
      DONE:     if (input_C_Ack) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // Datapath, handshake strobes and outputs
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      r_a <= '0; r_b <= '0; r_cbuf <= '0; output_C <= '0;
      r_i <= 3'd0; r_j <= 3'd0; r_k <= 3'd0; r_prod <= '0; r_acc <= '0;
      r_a_stb <= 1'b0; r_b_stb <= 1'b0; r_z_ack <= 1'b0; r_load <= 1'b0; r_res_ack <= 1'b0;
      output_AB_Ack <= 1'b0; output_Stable <= 1'b0; output_Free <= 1'b1;
    end else begin
      output_AB_Ack <= 1'b0;
      r_z_ack       <= 1'b0;
      r_load        <= 1'b0;
      r_res_ack     <= 1'b0;
      case (r_state)
        IDLE: if (input_Stable) begin
          r_a <= input_A; r_b <= input_B;
          r_i <= 3'd0; r_j <= 3'd0; r_k <= 3'd0;
          output_AB_Ack <= 1'b1; output_Free <= 1'b0;
          r_a_stb <= 1'b1; r_b_stb <= 1'b1;
        end
        MUL_REQ: begin
          if (w_a_ack) r_a_stb <= 1'b0;
          if (w_b_ack) r_b_stb <= 1'b0;
        end
        MUL_WAIT: if (w_z_stb) begin
          r_prod  <= w_z;
          r_z_ack <= 1'b1;
          if (r_k == 3'd0) r_acc  <= w_z;
          else             r_load <= 1'b1;
        end
        ADD_WAIT: if (w_res_ready) begin
          r_acc <= w_sum; r_res_ack <= 1'b1;
        end
        NEXT: begin
          if (!w_k_last) begin
            r_k <= r_k + 3'd1; r_a_stb <= 1'b1; r_b_stb <= 1'b1;
          end else begin
            r_cbuf <= w_cbuf_upd;
            r_k    <= 3'd0;
            if (w_j_last) begin
              r_j <= 3'd0;
              r_i <= w_i_last ? 3'd0 : r_i + 3'd1;
            end else begin
              r_j <= r_j + 3'd1;
            end
            if (w_i_last && w_j_last) begin
              output_C <= w_cbuf_upd; output_Stable <= 1'b1;
            end else begin
              r_a_stb <= 1'b1; r_b_stb <= 1'b1;
            end
          end
        end
        DONE: if (input_C_Ack) begin
          output_Stable <= 1'b0; output_Free <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  single_multiplier u_mul (
    .clk(input_Clk), .rst(input_Reset),
    .input_a(w_mul_a), .input_a_stb(r_a_stb), .input_a_ack(w_a_ack),
    .input_b(w_mul_b), .input_b_stb(r_b_stb), .input_b_ack(w_b_ack),
    .output_z(w_z), .output_z_stb(w_z_stb), .output_z_ack(r_z_ack),
    .output_State(w_mul_state)
  );

  adder u_add (
    .clk(input_Clk), .reset(input_Reset), .load(r_load),
    .Number1(r_acc), .Number2(r_prod),
    .Result(w_sum), .result_ready(w_res_ready), .result_ack(r_res_ack),
    .output_State(w_add_state)
  );

  assign output_Dbg_State = {w_add_state, w_mul_state, r_state};
endmodule

// File: tb/tb_nxn_matrix_multiplier.sv
// Bench for nxn_matrix_multiplier: N=1,2,3 instances share clock, reset,
// operand buses and C_Ack; each has its own input_Stable.
module tb_nxn_matrix_multiplier;
  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [287:0] a_bus, b_bus;
  logic [3:1]   stb;
  logic         c_ack;
  wire  [31:0]  c1;
  wire  [127:0] c2;
  wire  [287:0] c3;
  wire  [3:1]   abk, ostb, ofree;
  wire  [6:0]   dbg1, dbg2, dbg3;

  nxn_matrix_multiplier #(.N(1)) u_dut1 (
    .input_Clk(clk), .input_Reset(rst_n), .input_Stable(stb[1]),
    .input_A(a_bus[31:0]), .input_B(b_bus[31:0]), .output_AB_Ack(abk[1]),
    .output_C(c1), .output_Stable(ostb[1]), .input_C_Ack(c_ack),
    .output_Free(ofree[1]), .output_Dbg_State(dbg1));
  nxn_matrix_multiplier #(.N(2)) u_dut2 (
    .input_Clk(clk), .input_Reset(rst_n), .input_Stable(stb[2]),
    .input_A(a_bus[127:0]), .input_B(b_bus[127:0]), .output_AB_Ack(abk[2]),
    .output_C(c2), .output_Stable(ostb[2]), .input_C_Ack(c_ack),
    .output_Free(ofree[2]), .output_Dbg_State(dbg2));
  nxn_matrix_multiplier #(.N(3)) u_dut3 (
    .input_Clk(clk), .input_Reset(rst_n), .input_Stable(stb[3]),
    .input_A(a_bus), .input_B(b_bus), .output_AB_Ack(abk[3]),
    .output_C(c3), .output_Stable(ostb[3]), .input_C_Ack(c_ack),
    .output_Free(ofree[3]), .output_Dbg_State(dbg3));

  int n_vec = 0;
  int n_err = 0;
  int ma[9];
  int mb[9];
  int ack_cnt[4] = '{0, 0, 0, 0};

  // count AB_Ack pulses, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    for (int d = 1; d <= 3; d++) if (abk[d] === 1'b1) ack_cnt[d]++;
  end

  // scoreboard checks
  task automatic check_bus(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference model: exact integer arithmetic, then integer -> float encoding
  function automatic logic [31:0] i2f(int v);
    int p;
    if (v == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 24; b++) if (v[b]) p = b;
    return {1'b0, 8'(127 + p), 23'(v << (23 - p))};
  endfunction

  function automatic logic [287:0] ref_c(int n);
    logic [287:0] r = '0;
    int s;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += ma[i*n+k] * mb[k*n+j];
        r[(i*n+j)*32 +: 32] = i2f(s);
      end
    return r;
  endfunction

  function automatic logic [287:0] bus_of(int n, bit use_b);
    logic [287:0] r = '0;
    for (int e = 0; e < n*n; e++) r[e*32 +: 32] = i2f(use_b ? mb[e] : ma[e]);
    return r;
  endfunction

  function automatic logic [287:0] get_c(int n);
    case (n)
      1:       return 288'(c1);
      2:       return 288'(c2);
      default: return c3;
    endcase
  endfunction

  function automatic logic [6:0] get_dbg(int n);
    case (n)
      1:       return dbg1;
      2:       return dbg2;
      default: return dbg3;
    endcase
  endfunction

  task automatic fill_rand(input int n);
    for (int e = 0; e < 9; e++) begin
      ma[e] = (e < n*n) ? int'($urandom_range(0, 15)) : 0;
      mb[e] = (e < n*n) ? int'($urandom_range(0, 15)) : 0;
    end
  endtask

  // bounded wait: which 0 = AB_Ack, 1 = output_Stable
  task automatic wait_sig(input int n, input int which, input int max, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < max && !ok; t++) begin
      @(negedge clk);
      ok = (which == 0) ? abk[n] : ostb[n];
    end
  endtask

  task automatic consume(input int n, input string tag);
    c_ack = 1'b1;
    @(negedge clk);
    c_ack = 1'b0;
    check_bit({tag, "_stable_fall"}, ostb[n], 1'b0);
    check_bit({tag, "_free_rise"}, ofree[n], 1'b1);
  endtask

  // full job: capture, isolate operands, C_Ack noise while busy, check C, backpressure, consume
  task automatic run_job(input int n, input int hold, input string tag);
    logic [287:0] exp, held;
    int ack0;
    bit ok, free_bad, bp_bad;
    exp  = ref_c(n);
    ack0 = ack_cnt[n];
    @(negedge clk);
    check_bit({tag, "_free_idle"}, ofree[n], 1'b1);
    a_bus = bus_of(n, 1'b0);
    b_bus = bus_of(n, 1'b1);
    stb[n] = 1'b1;
    wait_sig(n, 0, 20, ok);
    check_bit({tag, "_ab_ack_seen"}, ok, 1'b1);
    stb[n] = 1'b0;
    a_bus = '1;
    b_bus = '1;
    check_bit({tag, "_free_low"}, ofree[n], 1'b0);
    c_ack = 1'b1;
    ok = 1'b0;
    free_bad = 1'b0;
    for (int t = 1; t <= 3000 && !ok; t++) begin
      @(negedge clk);
      if (t >= 2) c_ack = 1'b0;
      ok = ostb[n];
      if (ofree[n] !== 1'b0) free_bad = 1'b1;
    end
    c_ack = 1'b0;
    check_bit({tag, "_stable_seen"}, ok, 1'b1);
    check_bit({tag, "_free_low_busy"}, free_bad, 1'b0);
    check_bus({tag, "_c"}, get_c(n), exp);
    held = get_c(n);
    bp_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      stb[n] = h[0];
      @(negedge clk);
      if (ostb[n] !== 1'b1 || ofree[n] !== 1'b0 || get_c(n) !== held) bp_bad = 1'b1;
    end
    stb[n] = 1'b0;
    if (hold > 0) check_bit({tag, "_backpressure"}, bp_bad, 1'b0);
    consume(n, tag);
    check_int({tag, "_ab_ack_count"}, ack_cnt[n] - ack0, 1);
  endtask

  // directed steps
  initial begin
    logic [287:0] exp1, exp2, a1, b1, a2, b2;
    int ack0;
    bit ok;
    rst_n = 1'b0;
    stb   = '0;
    c_ack = 1'b0;
    a_bus = '0;
    b_bus = '0;
    repeat (3) @(negedge clk);
    for (int d = 1; d <= 3; d++) begin
      check_bus($sformatf("rst_c_n%0d", d), get_c(d), '0);
      check_bit($sformatf("rst_free_n%0d", d), ofree[d], 1'b1);
      check_bit($sformatf("rst_stable_n%0d", d), ostb[d], 1'b0);
      check_bit($sformatf("rst_abk_n%0d", d), abk[d], 1'b0);
      check_int($sformatf("rst_state_n%0d", d), int'(get_dbg(d)), 0);
    end
    rst_n = 1'b1;

    // 2x2 worked example with 20-cycle backpressure
    ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    run_job(2, 20, "mat2x2");
    check_bus("mat2x2_const", get_c(2),
              288'({32'h42480000, 32'h422C0000, 32'h41B00000, 32'h41980000}));

    // 3x3 identity times 1..9
    ma = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_job(3, 2, "ident3");
    check_bus("ident3_const", get_c(3),
              {32'h41100000, 32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
               32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});

    // 1x1
    ma = '{2, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = '{3, 0, 0, 0, 0, 0, 0, 0, 0};
    run_job(1, 1, "mat1x1");
    check_bus("mat1x1_const", get_c(1), 288'(32'h40C00000));

    // randomized jobs over all three sizes
    for (int r = 0; r < 9; r++) begin
      fill_rand(1 + r % 3);
      run_job(1 + r % 3, int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
    end

    // reset while the N=2 instance waits on the adder
    fill_rand(2);
    @(negedge clk);
    a_bus = bus_of(2, 1'b0);
    b_bus = bus_of(2, 1'b1);
    stb[2] = 1'b1;
    wait_sig(2, 0, 20, ok);
    stb[2] = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = (dbg2[2:0] == 3'd4);
    end
    check_bit("rstmid_reach_add_wait", ok, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bus("rstmid_c", get_c(2), '0);
    check_bit("rstmid_free", ofree[2], 1'b1);
    check_bit("rstmid_stable", ostb[2], 1'b0);
    check_bit("rstmid_abk", abk[2], 1'b0);
    check_int("rstmid_state", int'(dbg2), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_rand(2);
    run_job(2, 0, "after_rst");

    // back-to-back with input_Stable held high
    fill_rand(2);
    exp1 = ref_c(2); a1 = bus_of(2, 1'b0); b1 = bus_of(2, 1'b1);
    fill_rand(2);
    exp2 = ref_c(2); a2 = bus_of(2, 1'b0); b2 = bus_of(2, 1'b1);
    @(negedge clk);
    ack0 = ack_cnt[2];
    a_bus = a1;
    b_bus = b1;
    stb[2] = 1'b1;
    wait_sig(2, 0, 20, ok);
    check_bit("b2b_first_capture", ok, 1'b1);
    a_bus = a2;
    b_bus = b2;
    wait_sig(2, 1, 3000, ok);
    check_bit("b2b_first_done", ok, 1'b1);
    check_bus("b2b_first_c", get_c(2), exp1);
    repeat (3) @(negedge clk);
    check_int("b2b_single_ack_while_busy", ack_cnt[2] - ack0, 1);
    consume(2, "b2b_first");
    @(negedge clk);
    check_bit("b2b_second_capture", abk[2], 1'b1);
    stb[2] = 1'b0;
    wait_sig(2, 1, 3000, ok);
    check_bit("b2b_second_done", ok, 1'b1);
    check_bus("b2b_second_c", get_c(2), exp2);
    consume(2, "b2b_second");
    check_int("b2b_ack_total", ack_cnt[2] - ack0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
